// File: rtl/epl_accumulator.sv
// rtl/epl_accumulator.sv - early/prompt/late I/Q correlator with epoch-aligned dump
//
// Multiplies carrier-wiped I/Q samples by the early, prompt and late code bits
// and integrates the six products over INT_PERIODS code periods. The sums are
// dumped at each integration boundary, which is marked by an enabled epoch.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   enable                sample valid, one accumulation per enabled cycle
//   sample_i, sample_q    signed baseband samples (SAMPLE_WIDTH bits)
//   code_early/prompt/late code bits, 1 = +1, 0 = -1
//   epoch                 first sample of a new code period (qualified by enable)
//   clear                 drop the partial integration and return to unprimed
//   i_*/q_*               dumped signed sums (ACC_WIDTH bits), held between dumps
//   dump_valid            one-cycle strobe when the sums above were updated
//   dump_saturated        an accumulator clamped during the dumped interval
module epl_accumulator #(
    parameter int SAMPLE_WIDTH = 3,
    parameter int ACC_WIDTH    = 19,
    parameter int INT_PERIODS  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_i,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_q,
    input  logic                          code_early,
    input  logic                          code_prompt,
    input  logic                          code_late,
    input  logic                          epoch,
    input  logic                          clear,
    output logic signed [ACC_WIDTH-1:0]    i_early,
    output logic signed [ACC_WIDTH-1:0]    q_early,
    output logic signed [ACC_WIDTH-1:0]    i_prompt,
    output logic signed [ACC_WIDTH-1:0]    q_prompt,
    output logic signed [ACC_WIDTH-1:0]    i_late,
    output logic signed [ACC_WIDTH-1:0]    q_late,
    output logic                          dump_valid,
    output logic                          dump_saturated
);

    // Products carry one extra bit so that negating the most negative sample is exact.
    localparam int PW = SAMPLE_WIDTH + 1;

    // Symmetric clamp limits, expressed one bit wider than the accumulators.
    localparam logic signed [ACC_WIDTH:0] SAT_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = {2'b11, {(ACC_WIDTH-2){1'b0}}, 1'b1};
    localparam logic [7:0]                LAST_EPOCH = 8'(INT_PERIODS - 1);

    typedef enum logic {
        ST_UNPRIMED    = 1'b0,
        ST_INTEGRATING = 1'b1
    } state_t;

    // Channel order in all arrays: ie, qe, ip, qp, il, ql.
    state_t                      state_q, state_d;
    logic [7:0]                  cnt_q, cnt_d;
    logic                        sat_q, sat_d;
    logic                        dump_valid_q, dump_valid_d;
    logic                        dump_sat_q, dump_sat_d;
    logic signed [ACC_WIDTH-1:0] acc_q [6];
    logic signed [ACC_WIDTH-1:0] acc_d [6];
    logic signed [ACC_WIDTH-1:0] out_q [6];
    logic signed [ACC_WIDTH-1:0] out_d [6];

    logic signed [PW-1:0]        ext_i, ext_q;
    logic [2:0]                  code;
    logic signed [PW-1:0]        prod     [6];
    logic signed [ACC_WIDTH-1:0] prod_ext [6];
    logic signed [ACC_WIDTH:0]   sum      [6];
    logic signed [ACC_WIDTH-1:0] sum_sat  [6];
    logic [5:0]                  sat_hit;

    always_comb begin
        ext_i = {sample_i[SAMPLE_WIDTH-1], sample_i};
        ext_q = {sample_q[SAMPLE_WIDTH-1], sample_q};
        code  = {code_late, code_prompt, code_early};
        for (int k = 0; k < 3; k++) begin
            prod[2*k]   = code[k] ? ext_i : -ext_i;
            prod[2*k+1] = code[k] ? ext_q : -ext_q;
        end
    end

    // Saturating add: the sum is formed one bit wider so overflow is visible.
    always_comb begin
        for (int k = 0; k < 6; k++) begin
            prod_ext[k] = {{(ACC_WIDTH-PW){prod[k][PW-1]}}, prod[k]};
            sum[k]      = {acc_q[k][ACC_WIDTH-1], acc_q[k]}
                        + {prod_ext[k][ACC_WIDTH-1], prod_ext[k]};
            sat_hit[k]  = 1'b0;
            sum_sat[k]  = sum[k][ACC_WIDTH-1:0];
            if (sum[k] > SAT_MAX) begin
                sum_sat[k] = SAT_MAX[ACC_WIDTH-1:0];
                sat_hit[k] = 1'b1;
            end else if (sum[k] < SAT_MIN) begin
                sum_sat[k] = SAT_MIN[ACC_WIDTH-1:0];
                sat_hit[k] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sat_d        = sat_q;
        dump_valid_d = 1'b0;
        dump_sat_d   = dump_sat_q;
        acc_d        = acc_q;
        out_d        = out_q;

        if (clear) begin
            state_d = ST_UNPRIMED;
            cnt_d   = '0;
            sat_d   = 1'b0;
            for (int k = 0; k < 6; k++) acc_d[k] = '0;
        end else if (enable) begin
            case (state_q)
                ST_UNPRIMED: begin
                    // Samples before the first epoch are discarded.
                    if (epoch) begin
                        state_d = ST_INTEGRATING;
                        cnt_d   = '0;
                        sat_d   = 1'b0;
                        acc_d   = prod_ext;
                    end
                end
                default: begin
                    if (epoch && cnt_q == LAST_EPOCH) begin
                        // The epoch sample opens the next interval, not this one.
                        out_d        = acc_q;
                        dump_sat_d   = sat_q;
                        dump_valid_d = 1'b1;
                        acc_d        = prod_ext;
                        cnt_d        = '0;
                        sat_d        = 1'b0;
                    end else begin
                        acc_d = sum_sat;
                        sat_d = sat_q | (|sat_hit);
                        if (epoch) cnt_d = cnt_q + 8'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_UNPRIMED;
            cnt_q        <= '0;
            sat_q        <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_sat_q   <= 1'b0;
            for (int k = 0; k < 6; k++) begin
                acc_q[k] <= '0;
                out_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sat_q        <= sat_d;
            dump_valid_q <= dump_valid_d;
            dump_sat_q   <= dump_sat_d;
            acc_q        <= acc_d;
            out_q        <= out_d;
        end
    end

    assign i_early        = out_q[0];
    assign q_early        = out_q[1];
    assign i_prompt       = out_q[2];
    assign q_prompt       = out_q[3];
    assign i_late         = out_q[4];
    assign q_late         = out_q[5];
    assign dump_valid     = dump_valid_q;
    assign dump_saturated = dump_sat_q;

endmodule

// File: tb/tb_epl_accumulator.sv
// tb/tb_epl_accumulator.sv - self-checking bench for epl_accumulator
module tb_epl_accumulator;

    localparam int PERIOD = 1023;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, enable, code_early, code_prompt, code_late, epoch, clear;
    logic signed [2:0] sample_i, sample_q;

    logic signed [18:0] o1 [6];
    logic signed [18:0] o4 [6];
    logic signed [11:0] os [6];
    logic v1, s1, v4, s4, vs, ss;

    epl_accumulator #(.SAMPLE_WIDTH(3), .ACC_WIDTH(19), .INT_PERIODS(1)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .sample_i(sample_i), .sample_q(sample_q),
        .code_early(code_early), .code_prompt(code_prompt), .code_late(code_late),
        .epoch(epoch), .clear(clear),
        .i_early(o1[0]), .q_early(o1[1]), .i_prompt(o1[2]), .q_prompt(o1[3]),
        .i_late(o1[4]), .q_late(o1[5]), .dump_valid(v1), .dump_saturated(s1));

    epl_accumulator #(.SAMPLE_WIDTH(3), .ACC_WIDTH(19), .INT_PERIODS(4)) dut4 (
        .clk(clk), .reset(reset), .enable(enable), .sample_i(sample_i), .sample_q(sample_q),
        .code_early(code_early), .code_prompt(code_prompt), .code_late(code_late),
        .epoch(epoch), .clear(clear),
        .i_early(o4[0]), .q_early(o4[1]), .i_prompt(o4[2]), .q_prompt(o4[3]),
        .i_late(o4[4]), .q_late(o4[5]), .dump_valid(v4), .dump_saturated(s4));

    epl_accumulator #(.SAMPLE_WIDTH(3), .ACC_WIDTH(12), .INT_PERIODS(4)) duts (
        .clk(clk), .reset(reset), .enable(enable), .sample_i(sample_i), .sample_q(sample_q),
        .code_early(code_early), .code_prompt(code_prompt), .code_late(code_late),
        .epoch(epoch), .clear(clear),
        .i_early(os[0]), .q_early(os[1]), .i_prompt(os[2]), .q_prompt(os[3]),
        .i_late(os[4]), .q_late(os[5]), .dump_valid(vs), .dump_saturated(ss));

    int n_chk  = 0;
    int n_fail = 0;
    string nm [6] = '{"ie", "qe", "ip", "qp", "il", "ql"};

    // Reference model of dut1 (INT_PERIODS=1, no saturation reachable in these runs).
    int m_acc [6];
    int m_out [6];
    bit m_primed;
    bit m_valid;

    typedef struct {
        int en, si, sq, ce, cp, cl, ep, clr;
        int xv, xs, xie, xqe, xip, xqp, xil, xql;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int prodf(input int s, input logic b);
        return b ? s : -s;
    endfunction

    task automatic model_step();
        int p [6];
        logic [2:0] c;
        c = {code_late, code_prompt, code_early};
        for (int k = 0; k < 6; k++)
            p[k] = prodf((k % 2) ? int'(sample_q) : int'(sample_i), c[k/2]);
        m_valid = 1'b0;
        if (reset) begin
            for (int k = 0; k < 6; k++) begin m_acc[k] = 0; m_out[k] = 0; end
            m_primed = 1'b0;
        end else if (clear) begin
            for (int k = 0; k < 6; k++) m_acc[k] = 0;
            m_primed = 1'b0;
        end else if (enable) begin
            if (epoch) begin
                if (m_primed) begin
                    m_out   = m_acc;
                    m_valid = 1'b1;
                end
                m_acc    = p;
                m_primed = 1'b1;
            end else if (m_primed) begin
                for (int k = 0; k < 6; k++) m_acc[k] += p[k];
            end
        end
    endtask

    task automatic check_dut1(input string tag);
        chk({tag, "_valid"}, int'(v1), int'(m_valid));
        if (m_valid) chk({tag, "_sat"}, int'(s1), 0);
        for (int k = 0; k < 6; k++) chk({tag, "_", nm[k]}, int'(o1[k]), m_out[k]);
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_dut1(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; epoch = 1'b0; clear = 1'b0;
        cycle("rst");
        reset = 1'b0;
        chk("rst_v4", int'(v4), 0);
        chk("rst_ss", int'(ss), 0);
        chk("rst_os_ie", int'(os[0]), 0);
    endtask

    task automatic set_sample(input int mode, input int s);
        code_early = 1'b1; code_prompt = 1'b1; code_late = 1'b1;
        case (mode)
            1: begin sample_i = 3'sd1; sample_q = -3'sd1; end
            2: begin
                sample_i = -3'sd4; sample_q = -3'sd1;
                code_early = 1'b0; code_late = s[0];
            end
            default: begin
                sample_i = (s <= 4092) ? 3'sd3 : 3'sd0;
                sample_q = sample_i;
            end
        endcase
    endtask

    task automatic run_stream(input int n, input int mode, input int clear_at,
                              input int gap_a, input int gap_b, input int reset_at,
                              input bit chk4);
        for (int s = 0; s < n; s++) begin
            if (s == gap_a || s == gap_b) begin
                repeat (5) begin
                    enable = 1'b0; epoch = 1'b1; sample_i = 3'sd3; sample_q = -3'sd3;
                    cycle("gap");
                end
            end
            enable = 1'b1;
            set_sample(mode, s);
            epoch = (s % PERIOD == 0);
            clear = (s == clear_at);
            reset = (s == reset_at);
            cycle($sformatf("m%0d_s%0d", mode, s));
            reset = 1'b0;
            clear = 1'b0;
            if (m_valid && s > 0 && mode == 1) begin
                chk("s1_ie_const", int'(o1[0]), 1023);
                chk("s1_ql_const", int'(o1[5]), -1023);
            end
            if (m_valid && mode == 2) begin
                chk("s2_ie_const", int'(o1[0]), 4092);
                chk("s2_ip_const", int'(o1[2]), -4092);
                chk("s2_il_const", int'(o1[4]), ((s / PERIOD) % 2 == 1) ? 4 : -4);
                chk("s2_ql_const", int'(o1[5]), ((s / PERIOD) % 2 == 1) ? 1 : -1);
            end
            if (chk4) begin
                chk($sformatf("d4_valid_s%0d", s), int'(v4), int'(s > 0 && s % 4092 == 0));
                chk($sformatf("ds_valid_s%0d", s), int'(vs), int'(s > 0 && s % 4092 == 0));
                if (s == 4092) begin
                    chk("d4_ie_12276", int'(o4[0]), 12276);
                    chk("d4_sat0", int'(s4), 0);
                    chk("ds_ie_2047", int'(os[0]), 2047);
                    chk("ds_ql_2047", int'(os[5]), 2047);
                    chk("ds_sat1", int'(ss), 1);
                end else if (s == 8184) begin
                    chk("d4_ie_3", int'(o4[0]), 3);
                    chk("ds_ie_3", int'(os[0]), 3);
                    chk("ds_sat0", int'(ss), 0);
                end
            end
        end
    endtask

    initial begin
        //          en si sq ce cp cl ep clr  xv xs  ie qe ip qp il ql
        tbl[0]  = '{1,  1, -1, 1, 1, 1, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1,  2,  1, 1, 1, 1, 1, 0,  0, 0,  0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1,  3, -2, 0, 1, 1, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0};
        tbl[3]  = '{0,  3,  3, 1, 1, 1, 1, 0,  0, 0,  0, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, -4, -4, 1, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0};
        tbl[5]  = '{1,  1,  1, 1, 1, 1, 1, 0,  1, 0, -5,-1, 9, 3, 9, 3};
        tbl[6]  = '{1, -1,  0, 0, 0, 0, 1, 0,  1, 0,  1, 1, 1, 1, 1, 1};
        tbl[7]  = '{1,  1,  1, 1, 0, 1, 0, 1,  0, 0,  1, 1, 1, 1, 1, 1};
        tbl[8]  = '{1,  2,  2, 1, 1, 1, 1, 0,  0, 0,  1, 1, 1, 1, 1, 1};
        tbl[9]  = '{1,  1, -1, 1, 1, 1, 0, 0,  0, 0,  1, 1, 1, 1, 1, 1};
        tbl[10] = '{1,  0,  0, 1, 1, 1, 1, 0,  1, 0,  3, 1, 3, 1, 3, 1};
        tbl[11] = '{0,  0,  0, 1, 1, 1, 0, 0,  0, 0,  3, 1, 3, 1, 3, 1};

        reset = 1'b1; enable = 1'b0; epoch = 1'b0; clear = 1'b0;
        sample_i = '0; sample_q = '0;
        code_early = 1'b1; code_prompt = 1'b1; code_late = 1'b1;
        repeat (2) @(posedge clk);
        do_reset();

        for (int i = 0; i < 12; i++) begin
            int xo [6];
            enable      = (tbl[i].en != 0);
            sample_i    = 3'(tbl[i].si);
            sample_q    = 3'(tbl[i].sq);
            code_early  = (tbl[i].ce != 0);
            code_prompt = (tbl[i].cp != 0);
            code_late   = (tbl[i].cl != 0);
            epoch       = (tbl[i].ep != 0);
            clear       = (tbl[i].clr != 0);
            @(posedge clk);
            #1;
            xo = '{tbl[i].xie, tbl[i].xqe, tbl[i].xip, tbl[i].xqp, tbl[i].xil, tbl[i].xql};
            chk($sformatf("tbl%0d_valid", i), int'(v1), tbl[i].xv);
            chk($sformatf("tbl%0d_sat", i), int'(s1), tbl[i].xs);
            for (int k = 0; k < 6; k++)
                chk($sformatf("tbl%0d_%s", i, nm[k]), int'(o1[k]), xo[k]);
        end
        clear = 1'b0;

        do_reset();
        run_stream(2047, 1, -1, -1, -1, -1, 1'b0);

        do_reset();
        run_stream(4093, 2, 2546, 2700, 3500, -1, 1'b0);

        run_stream(1600, 1, -1, -1, -1, 1523, 1'b0);
        run_stream(2047, 1, -1, -1, -1, -1, 1'b0);

        do_reset();
        run_stream(8185, 3, -1, -1, -1, -1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
